audio_cts_meter: RTL and testbench
==================================

// Module: audio_cts_meter
// PURPOSE
//  Measures HDMI Audio Clock Regeneration CTS in the pixel clock domain: counts pixelClock cycles
//  across a window of samplesPerRegenPacket audio samples (= one 128*f_s/N period) and presents a
//  stable cts for the horizontal-blanking data island packet builder. Sits directly upstream of it;
//  cts feeds its cts input, samplesPerRegenPacket is shared with it.
// PARAMETERS
//  CTS_WIDTH    20  counter / cts width (HDMI field is 20 bits)
//  SYNC_STAGES  2   flops in sampleToggle synchronizer, legal range 2..4
// PORTS
//  pixelClock             in   1          sole clock, rising edge
//  resetN                 in   1          synchronous, active-low reset
//  enable                 in   1          measurement enable; low forces IDLE
//  sampleToggle           in   1          async, from audio domain; toggles once per audio sample
//  samplesPerRegenPacket  in   8          window length in samples; 0 treated as 1
//  cts                    out  CTS_WIDTH  last measured (or averaged) cycle count
//  ctsValid               out  1          cts holds a completed measurement
//  ctsUpdated             out  1          one-cycle pulse when cts is written
//  overflow               out  1          sticky: a window exceeded 2^CTS_WIDTH-1 cycles
// BEHAVIOUR
//  - Reset (resetN=0 at a clock edge): cts=0, ctsValid=0, ctsUpdated=0, overflow=0, state=IDLE,
//    synchronizer and edge-detect flops cleared; reset mid-window discards the partial window.
//  - samplePulse = edge detect (either edge) on synchronized sampleToggle; latency SYNC_STAGES+1
//    cycles from toggle to pulse; at most one pulse per cycle.
//  - States: IDLE -> ARM when enable=1. ARM -> MEASURE on first samplePulse (window start: latch
//    winLen = max(samplesPerRegenPacket,1), cycleCount<=1, sampleCount<=0). enable=0 in any state
//    -> IDLE next cycle, ctsValid<=0, cts held, overflow held.
//  - MEASURE: each cycle without closing pulse, cycleCount += 1 (saturates at 2^CTS_WIDTH-1; on
//    reaching saturation set overflow and mark window bad). Each samplePulse increments sampleCount;
//    the pulse where sampleCount+1 == winLen closes the window.
//  - Closing pulse: if window good, cts<=cycleCount, ctsUpdated=1 for that next cycle,
//    ctsValid<=1; if bad, cts/ctsValid unchanged, no ctsUpdated. Closing pulse is also next
//    window's start: cycleCount<=1, sampleCount<=0, winLen re-latched, bad flag cleared.
//  - cts equals clock edges between start pulse and closing pulse (D pulses apart -> cts=D).
//  - samplesPerRegenPacket changes mid-window take effect at next window start only.
//  - overflow clears only on reset.
// CONFIGURATION
//  AUDIO_CTS_AVG_EN defined: keep last 4 good window counts in a shift register; cts = sum>>2
//   (CTS_WIDTH+2-bit sum, truncating); ctsValid only after 4 good windows since IDLE exit;
//   bad window or IDLE flushes history.
//  Undefined: cts = raw count of latest good window; ctsValid after first good window.
// TESTING
//  1 Reset: hold resetN=0 with toggling input -> all outputs 0, no ctsUpdated.
//  2 Toggle every 1500 cycles, samplesPerRegenPacket=48 -> cts=72000, ctsValid=1, one ctsUpdated
//    per 48 samples, first update 48 samples after first pulse.
//  3 samplesPerRegenPacket=0, toggle every 100 cycles -> cts=100 each sample; change to 4
//    mid-window -> current window closes per old length, next gives cts=400.
//  4 Toggle stops for >2^20 cycles in MEASURE -> overflow=1 sticky, cts/ctsValid hold old value;
//    toggles resume -> next full window updates cts normally.
//  5 enable dropped mid-window -> ctsValid=0 next cycle; re-enable -> new window from next pulse.
//  6 AUDIO_CTS_AVG_EN, windows of 1000,1001,1002,1004 cycles -> ctsValid only after 4th, cts=1001.

Source files
------------

// File: rtl/audio_cts_meter.sv
// HDMI ACR CTS meter: counts pixelClock cycles over a window of audio samples.
// Optional AUDIO_CTS_AVG_EN: report the truncating mean of the last four good windows.
module audio_cts_meter #(
    parameter int CTS_WIDTH   = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 pixelClock,
    input  logic                 resetN,
    input  logic                 enable,
    input  logic                 sampleToggle,
    input  logic [7:0]           samplesPerRegenPacket,
    output logic [CTS_WIDTH-1:0] cts,
    output logic                 ctsValid,
    output logic                 ctsUpdated,
    output logic                 overflow
);

    localparam logic [CTS_WIDTH-1:0] CNT_MAX = {CTS_WIDTH{1'b1}};
    localparam logic [CTS_WIDTH-1:0] CNT_ONE = {{(CTS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   pulse_q, pulse_d;
    logic [CTS_WIDTH-1:0]   cycle_count_q, cycle_count_d;
    logic [7:0]             sample_count_q, sample_count_d;
    logic [7:0]             win_len_q, win_len_d;
    logic                   bad_q, bad_d;
    logic [CTS_WIDTH-1:0]   cts_q, cts_d;
    logic                   cts_valid_q, cts_valid_d;
    logic                   cts_updated_q, cts_updated_d;
    logic                   overflow_q, overflow_d;
`ifdef AUDIO_CTS_AVG_EN
    logic [2:0][CTS_WIDTH-1:0] hist_q, hist_d;
    logic [2:0]                hist_n_q, hist_n_d;
    logic [CTS_WIDTH+1:0]      sum_s;
`endif

    assign cts        = cts_q;
    assign ctsValid   = cts_valid_q;
    assign ctsUpdated = cts_updated_q;
    assign overflow   = overflow_q;

    // Next-state logic: synchronizer, edge detect, window FSM and result update
    always_comb begin
        sync_d         = {sync_q[SYNC_STAGES-2:0], sampleToggle};
        last_d         = sync_q[SYNC_STAGES-1];
        pulse_d        = sync_q[SYNC_STAGES-1] ^ last_q;
        state_d        = state_q;
        cycle_count_d  = cycle_count_q;
        sample_count_d = sample_count_q;
        win_len_d      = win_len_q;
        bad_d          = bad_q;
        cts_d          = cts_q;
        cts_valid_d    = cts_valid_q;
        cts_updated_d  = 1'b0;
        overflow_d     = overflow_q;
`ifdef AUDIO_CTS_AVG_EN
        hist_d   = hist_q;
        hist_n_d = hist_n_q;
        sum_s    = {2'b00, cycle_count_q} + {2'b00, hist_q[0]}
                 + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
`endif
        if (!enable) begin
            state_d     = IDLE;
            cts_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
`ifdef AUDIO_CTS_AVG_EN
                    hist_n_d = 3'd0;
`endif
                end
                ARM: begin
                    if (pulse_q) begin
                        state_d        = MEASURE;
                        win_len_d      = (samplesPerRegenPacket == 8'd0) ? 8'd1 : samplesPerRegenPacket;
                        cycle_count_d  = CNT_ONE;
                        sample_count_d = 8'd0;
                        bad_d          = 1'b0;
                    end else begin
                        state_d = ARM;
                    end
                end
                MEASURE: begin
                    if (pulse_q && (sample_count_q + 8'd1 == win_len_q)) begin
                        // Closing pulse doubles as the start of the next window
                        win_len_d      = (samplesPerRegenPacket == 8'd0) ? 8'd1 : samplesPerRegenPacket;
                        cycle_count_d  = CNT_ONE;
                        sample_count_d = 8'd0;
                        bad_d          = 1'b0;
                        if (!bad_q) begin
`ifdef AUDIO_CTS_AVG_EN
                            hist_d[0] = cycle_count_q;
                            hist_d[1] = hist_q[0];
                            hist_d[2] = hist_q[1];
                            if (hist_n_q >= 3'd3) begin
                                hist_n_d      = 3'd4;
                                cts_d         = CTS_WIDTH'(sum_s >> 2);
                                cts_valid_d   = 1'b1;
                                cts_updated_d = 1'b1;
                            end else begin
                                hist_n_d = hist_n_q + 3'd1;
                            end
`else
                            cts_d         = cycle_count_q;
                            cts_valid_d   = 1'b1;
                            cts_updated_d = 1'b1;
`endif
                        end else begin
`ifdef AUDIO_CTS_AVG_EN
                            hist_n_d = 3'd0;
`else
                            cts_updated_d = 1'b0;
`endif
                        end
                    end else begin
                        if (pulse_q) begin
                            sample_count_d = sample_count_q + 8'd1;
                        end else begin
                            sample_count_d = sample_count_q;
                        end
                        if (cycle_count_q != CNT_MAX) begin
                            cycle_count_d = cycle_count_q + CNT_ONE;
                            if (cycle_count_d == CNT_MAX) begin
                                overflow_d = 1'b1;
                                bad_d      = 1'b1;
                            end else begin
                                overflow_d = overflow_q;
                            end
                        end else begin
                            cycle_count_d = CNT_MAX;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            state_q        <= IDLE;
            sync_q         <= '0;
            last_q         <= 1'b0;
            pulse_q        <= 1'b0;
            cycle_count_q  <= '0;
            sample_count_q <= 8'd0;
            win_len_q      <= 8'd1;
            bad_q          <= 1'b0;
            cts_q          <= '0;
            cts_valid_q    <= 1'b0;
            cts_updated_q  <= 1'b0;
            overflow_q     <= 1'b0;
`ifdef AUDIO_CTS_AVG_EN
            hist_q         <= '0;
            hist_n_q       <= 3'd0;
`endif
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            last_q         <= last_d;
            pulse_q        <= pulse_d;
            cycle_count_q  <= cycle_count_d;
            sample_count_q <= sample_count_d;
            win_len_q      <= win_len_d;
            bad_q          <= bad_d;
            cts_q          <= cts_d;
            cts_valid_q    <= cts_valid_d;
            cts_updated_q  <= cts_updated_d;
            overflow_q     <= overflow_d;
`ifdef AUDIO_CTS_AVG_EN
            hist_q         <= hist_d;
            hist_n_q       <= hist_n_d;
`endif
        end
    end

endmodule

// File: tb/tb_audio_cts_meter.sv
// Scoreboard bench for audio_cts_meter; CTS_WIDTH is narrowed to 14 so overflow is reachable quickly.
module tb_audio_cts_meter;

    localparam int W = 14;

    logic         clk;
    logic         resetN;
    logic         enable;
    logic         sampleToggle;
    logic [7:0]   spp;
    logic [W-1:0] cts;
    logic         ctsValid;
    logic         ctsUpdated;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    int m_cts   = 0;
    int m_valid = 0;
    int m_hist[4];
    int m_n     = 0;

    audio_cts_meter #(.CTS_WIDTH(W), .SYNC_STAGES(2)) dut (
        .pixelClock(clk),
        .resetN(resetN),
        .enable(enable),
        .sampleToggle(sampleToggle),
        .samplesPerRegenPacket(spp),
        .cts(cts),
        .ctsValid(ctsValid),
        .ctsUpdated(ctsUpdated),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a good window of v cycles
    task automatic m_good(input int v);
`ifdef AUDIO_CTS_AVG_EN
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = v;
        if (m_n < 4) m_n++;
        if (m_n == 4) begin
            m_cts   = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
            m_valid = 1;
            exp_q.push_back(m_cts);
        end
`else
        m_cts   = v;
        m_valid = 1;
        exp_q.push_back(v);
`endif
    endtask

    task automatic m_bad();
        m_n = 0;
    endtask

    task automatic m_idle();
        m_n     = 0;
        m_valid = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_n(input int period, input int n, input int chg_at, input logic [7:0] chg_val);
        for (int i = 0; i < n; i++) begin
            tick(period / 2);
            if (i == chg_at) spp = chg_val;
            tick(period - period / 2);
            sampleToggle = ~sampleToggle;
        end
    endtask

    // Monitor: every ctsUpdated pulse must match the oldest expected value
    always @(negedge clk) begin
        if (resetN && ctsUpdated) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_update: got cts=%0d expected no update", cts);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cts !== W'(e) || ctsValid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL update_value: got cts=%0d valid=%0b expected cts=%0d valid=1", cts, ctsValid, e);
                end
            end
        end
    end

    initial begin
        resetN = 1'b0; enable = 1'b0; sampleToggle = 1'b0; spp = 8'd48;
        // 1: reset holds everything at zero even with the toggle moving
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (i % 3 == 0) sampleToggle = ~sampleToggle;
            if (i > 0) chk("reset_outputs", {cts, ctsValid, ctsUpdated, overflow}, 0);
        end
        sampleToggle = 1'b0;
        tick(4);
        resetN = 1'b1;
        tick(6);
        chk("post_reset_valid", ctsValid, 0);

        // 2: 48 samples, 30 cycles apart -> 1440 per window
        enable = 1'b1;
        tick(3);
        m_good(1440); m_good(1440);
        toggle_n(30, 97, -1, 8'd0);
        tick(10);
        chk("t2_cts", cts, m_cts);
        chk("t2_valid", ctsValid, m_valid);
        chk("t2_overflow", overflow, 0);

        // 3: length 0 acts as 1; change to 4 mid-window applies at next start
        enable = 1'b0; m_idle(); tick(3);
        chk("t3_valid_dropped", ctsValid, 0);
        spp = 8'd0; enable = 1'b1; tick(3);
        for (int i = 0; i < 6; i++) m_good(20);
        m_good(80);
        toggle_n(20, 6, -1, 8'd0);
        toggle_n(20, 5, 0, 8'd4);
        tick(8);
        chk("t3_cts", cts, m_cts);

        // 4: toggles stop long enough to saturate the counter
        tick(16400);
        chk("t4_overflow", overflow, 1);
        chk("t4_cts_held", cts, m_cts);
        chk("t4_valid_held", ctsValid, m_valid);
        m_bad();
        toggle_n(20, 4, -1, 8'd0);
        m_good(80);
        toggle_n(20, 4, -1, 8'd0);
        tick(8);
        chk("t4_cts_resumed", cts, m_cts);
        chk("t4_overflow_sticky", overflow, 1);

        // 5: enable dropped mid-window
        toggle_n(20, 2, -1, 8'd0);
        tick(10);
        enable = 1'b0; m_idle();
        tick(1);
        chk("t5_valid_next_cycle", ctsValid, 0);
        chk("t5_cts_held", cts, m_cts);
        tick(5);
        enable = 1'b1;
        m_good(100);
        toggle_n(25, 5, -1, 8'd0);
        tick(8);
        chk("t5_cts_new", cts, m_cts);
        chk("t5_valid", ctsValid, m_valid);

        // 6: windows of 1000, 1001, 1002, 1004 cycles
        enable = 1'b0; m_idle(); tick(5);
        spp = 8'd1; enable = 1'b1; tick(10);
        sampleToggle = ~sampleToggle;
        m_good(1000); tick(1000); sampleToggle = ~sampleToggle;
        m_good(1001); tick(1001); sampleToggle = ~sampleToggle;
        m_good(1002); tick(1002); sampleToggle = ~sampleToggle;
        m_good(1004); tick(6);
        chk("t6_valid_after_3", ctsValid, m_valid);
        tick(998); sampleToggle = ~sampleToggle;
        tick(6);
        chk("t6_cts", cts, m_cts);
        chk("t6_valid", ctsValid, m_valid);

        tick(20);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
